// File: rtl/cacheline_burst_adapter.sv
// Cache line <-> burst memory adapter: assembles read beats into a line,
// splits a write-back line into beats. One transaction in flight.
module cacheline_burst_adapter #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_W-1:0] OMASK = ADDR_W'(LINE_W / 8 - 1);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic [LINE_W-1:0]   buf_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BURST_W-1:0]  burst_q;
  logic                read_q;
  logic                write_q;
  logic                resp_q;
  logic                last;

  assign cnt_d = cnt_q + 1'b1;
  assign last  = (cnt_q == LAST);

  assign line_o    = buf_q;
  assign address_o = addr_q;
  assign burst_o   = burst_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
      burst_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // write-back goes first so a pending fill never reads stale memory
          if (write_i) begin
            buf_q   <= line_i;
            addr_q  <= address_i & ~OMASK;
            cnt_q   <= '0;
            burst_q <= line_i[BURST_W-1:0];
            write_q <= 1'b1;
            state_q <= WR;
          end else if (read_i) begin
            addr_q  <= address_i & ~OMASK;
            cnt_q   <= '0;
            read_q  <= 1'b1;
            state_q <= RD;
          end
        end
        RD: begin
          if (resp_i) begin
            buf_q[int'(cnt_q)*BURST_W +: BURST_W] <= burst_i;
            cnt_q <= cnt_d;
            if (last) begin
              read_q  <= 1'b0;
              state_q <= DONE;
            end
          end
        end
        WR: begin
          if (resp_i) begin
            cnt_q   <= cnt_d;
            burst_q <= buf_q[int'(cnt_d)*BURST_W +: BURST_W];
            if (last) begin
              write_q <= 1'b0;
              burst_q <= '0;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          resp_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
